// File: rtl/ram_pkg.sv
// Shared constants and helpers for the multiport RAM.
// Holds the legal read-latency values and the port-index width helper.
package ram_pkg;

    localparam int LAT_SHORT = 1;
    localparam int LAT_LONG  = 2;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters.
// Ports: clk, rst (sync, active-high), valid in, grant out.
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] valid,
    output logic [PORTS-1:0] grant
);

    localparam int IW = idx_width(PORTS);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] cand;
    logic          found;

    // Search from the pointer upward, wrapping to 0; first valid wins.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        cand     = '0;
        found    = 1'b0;
        if (!rst) begin
            for (int k = 0; k < PORTS; k++) begin
                cand = IW'((int'(ptr) + k) % PORTS);
                if (!found && valid[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    ptr_next    = IW'((int'(cand) + 1) % PORTS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/multiport_ram.sv
// Single-storage RAM shared by PORTS requesters, one access per cycle.
// Ports: clk, rst, req_valid/write/addr/wdata, req_ready, rsp_valid/rdata.
module multiport_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 8,
    parameter int PORTS        = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 req_valid,
    input  logic [PORTS-1:0]                 req_write,
    input  logic [PORTS-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [PORTS-1:0]                 req_ready,
    output logic [PORTS-1:0]                 rsp_valid,
    output logic [PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [PORTS-1:0]      grant;
    logic [PORTS-1:0]      rd_hit;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [PORTS-1:0]      fin_v;
    logic [DATA_WIDTH-1:0] fin_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rr_arbiter #(
        .PORTS(PORTS)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .valid(req_valid),
        .grant(grant)
    );

    assign req_ready = grant;
    assign rd_hit    = grant & ~req_write;

    // Grant is one-hot, so the OR-free mux just picks the granted port.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i];
                sel_wdata = req_wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|grant && sel_write) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Data is captured at the grant edge, so later writes cannot leak in.
    assign rd_word = mem[sel_addr];

    generate
        if (READ_LATENCY == LAT_LONG) begin : g_lat2
            logic [PORTS-1:0]      s_v;
            logic [DATA_WIDTH-1:0] s_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_v    <= '0;
                    s_data <= '0;
                end else begin
                    s_v    <= rd_hit;
                    s_data <= rd_word;
                end
            end

            assign fin_v    = s_v;
            assign fin_data = s_data;
        end else begin : g_lat1
            assign fin_v    = rd_hit;
            assign fin_data = rd_word;
        end
    endgenerate

    // Per-port data registers hold their value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= fin_v;
            for (int i = 0; i < PORTS; i++) begin
                if (fin_v[i]) begin
                    rsp_rdata[i] <= fin_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_ram.sv
// Testbench for multiport_ram: directed table, hand sequences, random run.
// Instance a: defaults (2 ports, latency 1); instance b: 3 ports, latency 2.
module tb_multiport_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---- instance a ----
    logic             a_rst;
    logic [1:0]       a_valid, a_write, a_ready, a_rsp_valid;
    logic [1:0][16:0] a_addr;
    logic [1:0][7:0]  a_wdata, a_rdata;

    multiport_ram u_a (
        .clk      (clk),
        .rst      (a_rst),
        .req_valid(a_valid),
        .req_write(a_write),
        .req_addr (a_addr),
        .req_wdata(a_wdata),
        .req_ready(a_ready),
        .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata)
    );

    // ---- instance b ----
    logic             b_rst;
    logic [2:0]       b_valid, b_write, b_ready, b_rsp_valid;
    logic [2:0][16:0] b_addr;
    logic [2:0][7:0]  b_wdata, b_rdata;

    multiport_ram #(
        .ADDR_WIDTH  (17),
        .DATA_WIDTH  (8),
        .PORTS       (3),
        .READ_LATENCY(2)
    ) u_b (
        .clk      (clk),
        .rst      (b_rst),
        .req_valid(b_valid),
        .req_write(b_write),
        .req_addr (b_addr),
        .req_wdata(b_wdata),
        .req_ready(b_ready),
        .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // ---- directed table for instance a ----
    typedef struct {
        logic        rst;
        logic [1:0]  v, w;
        logic [16:0] a0, a1;
        logic [7:0]  d0, d1;
        logic [1:0]  rdy, rv;
        logic [7:0]  q0, q1;
    } vec_t;

    vec_t vt[20];

    // ---- hand-sequence step for instance b ----
    task automatic b_step(input logic r, input logic [2:0] v, w,
                          input logic [16:0] a0, a1, a2,
                          input logic [7:0] d0, d1, d2,
                          input logic [2:0] erdy, erv,
                          input logic [7:0] eq, input int qp);
        @(posedge clk); #1;
        b_rst = r;
        b_valid = v;
        b_write = w;
        b_addr[0] = a0;
        b_addr[1] = a1;
        b_addr[2] = a2;
        b_wdata[0] = d0;
        b_wdata[1] = d1;
        b_wdata[2] = d2;
        @(negedge clk);
        chk("b_ready", b_ready, erdy);
        chk("b_rsp_valid", b_rsp_valid, erv);
        if (qp >= 0) chk("b_rdata", b_rdata[qp], eq);
    endtask

    // ---- reference model for the random run on instance b ----
    typedef struct {
        int         p;
        logic [7:0] d;
        int         due;
    } ent_t;

    logic [7:0] mm [int];
    ent_t       rq[$];
    logic [7:0] last [3];
    int         mptr;
    int         cyc;
    int         pre;
    bit         pv [3];
    bit         pw [3];
    int         pa [3];
    logic [7:0] pd [3];

    // New request for a port; port 0 first fills addresses 0..15.
    task automatic gen(input int p);
        if (pre < 16) begin
            pv[p] = (p == 0);
            pw[p] = 1'b1;
            pa[p] = pre;
            pd[p] = 8'($urandom);
            if (p == 0) pre++;
        end else begin
            pv[p] = ($urandom % 4) != 0;
            pw[p] = 1'($urandom % 2);
            pa[p] = int'($urandom % 16);
            pd[p] = 8'($urandom);
        end
    endtask

    task automatic rand_cycle();
        logic [2:0] erv;
        logic [2:0] erdy;
        int g;
        @(posedge clk); #1;
        b_rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            b_valid[p] = pv[p];
            b_write[p] = pw[p];
            b_addr[p] = 17'(pa[p]);
            b_wdata[p] = pd[p];
        end
        @(negedge clk);
        erv = '0;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].p] = 1'b1;
            last[rq[0].p] = rq[0].d;
            void'(rq.pop_front());
        end
        chk("rnd_rsp_valid", b_rsp_valid, erv);
        for (int p = 0; p < 3; p++) chk("rnd_rdata", b_rdata[p], last[p]);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && pv[(mptr + k) % 3]) g = (mptr + k) % 3;
        end
        erdy = '0;
        if (g >= 0) erdy[g] = 1'b1;
        chk("rnd_ready", b_ready, erdy);
        if (g >= 0) begin
            if (pw[g]) mm[pa[g]] = pd[g];
            else rq.push_back('{g, mm[pa[g]], cyc + 2});
            mptr = (g + 1) % 3;
        end
        for (int p = 2; p >= 0; p--) begin
            if (!pv[p] || p == g) gen(p);
        end
        cyc++;
    endtask

    initial begin
        a_rst = 1'b1; a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0;
        b_rst = 1'b1; b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0;

        //         rst  v      w      a0        a1     d0     d1     rdy    rv     q0     q1
        vt[0]  = '{1, 2'b11, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b00, 8'h0,  8'h0};
        vt[1]  = '{0, 2'b01, 2'b01, 17'h10,   17'h0,  8'h5A, 8'h0,  2'b01, 2'b00, 8'h0,  8'h0};
        vt[2]  = '{0, 2'b01, 2'b00, 17'h10,   17'h0,  8'h0,  8'h0,  2'b01, 2'b00, 8'h0,  8'h0};
        vt[3]  = '{0, 2'b00, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b01, 8'h5A, 8'h0};
        vt[4]  = '{0, 2'b00, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b00, 8'h5A, 8'h0};
        vt[5]  = '{1, 2'b11, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b00, 8'h5A, 8'h0};
        vt[6]  = '{0, 2'b11, 2'b11, 17'h20,   17'h21, 8'hA1, 8'hB2, 2'b01, 2'b00, 8'h0,  8'h0};
        vt[7]  = '{0, 2'b11, 2'b11, 17'h22,   17'h21, 8'hC3, 8'hB2, 2'b10, 2'b00, 8'h0,  8'h0};
        vt[8]  = '{0, 2'b11, 2'b11, 17'h22,   17'h23, 8'hC3, 8'hD4, 2'b01, 2'b00, 8'h0,  8'h0};
        vt[9]  = '{0, 2'b11, 2'b10, 17'h20,   17'h23, 8'h0,  8'hD4, 2'b10, 2'b00, 8'h0,  8'h0};
        vt[10] = '{0, 2'b11, 2'b00, 17'h20,   17'h21, 8'h0,  8'h0,  2'b01, 2'b00, 8'h0,  8'h0};
        vt[11] = '{0, 2'b11, 2'b00, 17'h22,   17'h21, 8'h0,  8'h0,  2'b10, 2'b01, 8'hA1, 8'h0};
        vt[12] = '{0, 2'b11, 2'b00, 17'h22,   17'h23, 8'h0,  8'h0,  2'b01, 2'b10, 8'hA1, 8'hB2};
        vt[13] = '{0, 2'b10, 2'b00, 17'h0,    17'h23, 8'h0,  8'h0,  2'b10, 2'b01, 8'hC3, 8'hB2};
        vt[14] = '{0, 2'b00, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b10, 8'hC3, 8'hD4};
        vt[15] = '{0, 2'b11, 2'b11, 17'h1FFFF, 17'h0, 8'hFF, 8'h01, 2'b01, 2'b00, 8'hC3, 8'hD4};
        vt[16] = '{0, 2'b11, 2'b10, 17'h1FFFF, 17'h0, 8'h0,  8'h01, 2'b10, 2'b00, 8'hC3, 8'hD4};
        vt[17] = '{0, 2'b11, 2'b00, 17'h1FFFF, 17'h0, 8'h0,  8'h0,  2'b01, 2'b00, 8'hC3, 8'hD4};
        vt[18] = '{0, 2'b10, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b10, 2'b01, 8'hFF, 8'hD4};
        vt[19] = '{0, 2'b00, 2'b00, 17'h0,    17'h0,  8'h0,  8'h0,  2'b00, 2'b10, 8'hFF, 8'h01};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            a_rst = vt[i].rst;
            a_valid = vt[i].v;
            a_write = vt[i].w;
            a_addr[0] = vt[i].a0;
            a_addr[1] = vt[i].a1;
            a_wdata[0] = vt[i].d0;
            a_wdata[1] = vt[i].d1;
            @(negedge clk);
            chk($sformatf("a_ready[%0d]", i), a_ready, vt[i].rdy);
            chk($sformatf("a_rsp_valid[%0d]", i), a_rsp_valid, vt[i].rv);
            chk($sformatf("a_rdata0[%0d]", i), a_rdata[0], vt[i].q0);
            chk($sformatf("a_rdata1[%0d]", i), a_rdata[1], vt[i].q1);
        end

        // Read-before-write ordering, wrap-around, reset mid-read.
        b_step(0, 3'b001, 3'b001, 17'h3, 17'h0, 17'h0, 8'h11, 8'h0, 8'h0, 3'b001, 3'b000, 8'h00, 0);
        b_step(0, 3'b001, 3'b000, 17'h3, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b001, 3'b000, 8'h00, -1);
        b_step(0, 3'b010, 3'b010, 17'h0, 17'h3, 17'h0, 8'h0, 8'h22, 8'h0, 3'b010, 3'b000, 8'h00, -1);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b001, 8'h11, 0);
        b_step(0, 3'b001, 3'b000, 17'h3, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b001, 3'b000, 8'h11, 0);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b000, 8'h00, -1);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b001, 8'h22, 0);
        b_step(0, 3'b010, 3'b010, 17'h0, 17'h5, 17'h0, 8'h0, 8'h33, 8'h0, 3'b010, 3'b000, 8'h00, -1);
        b_step(0, 3'b101, 3'b100, 17'h3, 17'h0, 17'h6, 8'h0, 8'h0, 8'h44, 3'b100, 3'b000, 8'h00, -1);
        b_step(0, 3'b001, 3'b000, 17'h3, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b001, 3'b000, 8'h00, -1);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b000, 8'h00, -1);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b001, 8'h22, 0);
        b_step(0, 3'b001, 3'b000, 17'h3, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b001, 3'b000, 8'h00, -1);
        b_step(1, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b000, 8'h22, 0);
        b_step(0, 3'b011, 3'b000, 17'h5, 17'h6, 17'h0, 8'h0, 8'h0, 8'h0, 3'b001, 3'b000, 8'h00, 0);
        b_step(0, 3'b010, 3'b000, 17'h0, 17'h6, 17'h0, 8'h0, 8'h0, 8'h0, 3'b010, 3'b000, 8'h00, 0);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b001, 8'h33, 0);
        b_step(0, 3'b000, 3'b000, 17'h0, 17'h0, 17'h0, 8'h0, 8'h0, 8'h0, 3'b000, 3'b010, 8'h44, 1);

        // Random traffic on instance b against the queue/array model.
        @(posedge clk); #1;
        b_rst = 1'b1;
        b_valid = '0;
        @(posedge clk);
        mptr = 0;
        cyc = 0;
        pre = 0;
        for (int p = 0; p < 3; p++) begin
            last[p] = 8'h0;
            pv[p] = 1'b0;
        end
        for (int p = 2; p >= 0; p--) gen(p);
        repeat (1500) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
